flex_fifo_adapter: RTL

//   First-word-fall-through FIFO with a width converter in either direction.

---
 rtl/flex_fifo_if.sv | 27 ++
 rtl/flex_fifo_adapter.sv | 108 ++++++++++
 2 files changed

// File: rtl/flex_fifo_if.sv
// Write/read stream bus of the width-converting FIFO; the FIFO sits on the slave side.
interface flex_fifo_if #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 128,
  parameter int ADDR_WIDTH     = 8
);
  logic                      wr_ena;
  logic [DATA_IN_WIDTH-1:0]  wr_dat;
  logic                      wr_last;
  logic                      wr_full;
  logic                      rd_ena;
  logic [DATA_OUT_WIDTH-1:0] rd_dat;
  logic                      rd_last;
  logic                      rd_empty;
  logic [ADDR_WIDTH:0]       rd_dat_cnt;
  logic                      err_ovf;
  logic                      err_udf;

  modport master (
    output wr_ena, wr_dat, wr_last, rd_ena,
    input  wr_full, rd_dat, rd_last, rd_empty, rd_dat_cnt, err_ovf, err_udf
  );
  modport slave (
    input  wr_ena, wr_dat, wr_last, rd_ena,
    output wr_full, rd_dat, rd_last, rd_empty, rd_dat_cnt, err_ovf, err_udf
  );
endinterface

// File: rtl/flex_fifo_adapter.sv
// FWFT FIFO with upsize packing on write or downsize unpacking on read, packet-last
// framing, partial-word flush on last, and sticky overflow/underflow flags.
module flex_fifo_adapter #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 128,
  parameter int ADDR_WIDTH     = 8,
  parameter int FULL_SLACK     = 1,
  parameter int MSB_FIRST      = 1
) (
  input  logic       clk,
  input  logic       rstn,
  flex_fifo_if.slave bus
);
  localparam int IW    = DATA_IN_WIDTH;
  localparam int OW    = DATA_OUT_WIDTH;
  localparam int W     = (IW > OW) ? IW : OW;
  localparam int NW    = (IW > OW) ? OW : IW;
  localparam int R     = W / NW;
  localparam int WR_R  = (IW < OW) ? R : 1;
  localparam int RD_R  = (IW > OW) ? R : 1;
  localparam int LW    = (R > 1) ? $clog2(R) : 1;
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FULL_AT = CW'(DEPTH - FULL_SLACK);

  logic [W:0]            mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LW-1:0]         wlane_q, wlane_d, rlane_q, rlane_d;
  logic [W-1:0]          acc_q, acc_d, wword;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  full, empty, wr_acc, rd_acc, push, pop;
  logic [W:0]            head;
  int                    wsh, rsh;

  // Flags come from registered count only, so no ena->flag combinational path.
  assign full   = (cnt_q >= FULL_AT);
  assign empty  = (cnt_q == '0);
  assign wr_acc = bus.wr_ena & ~full;
  assign rd_acc = bus.rd_ena & ~empty;
  assign push   = wr_acc & ((wlane_q == LW'(WR_R - 1)) | bus.wr_last);
  assign pop    = rd_acc & (rlane_q == LW'(RD_R - 1));

  // Lane offsets collapse to zero on the side that is already full width.
  always_comb begin
    wsh   = (MSB_FIRST != 0) ? (WR_R - 1 - int'(wlane_q)) * IW : int'(wlane_q) * IW;
    rsh   = (MSB_FIRST != 0) ? (RD_R - 1 - int'(rlane_q)) * OW : int'(rlane_q) * OW;
    wword = acc_q | (W'(bus.wr_dat) << wsh);
    head  = mem_q[rptr_q];
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    acc_d   = acc_q;
    wlane_d = wlane_q;
    rlane_d = rlane_q;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    ovf_d   = ovf_q | (bus.wr_ena & full);
    udf_d   = udf_q | (bus.rd_ena & empty);
    if (push) wptr_d = wptr_q + ADDR_WIDTH'(1);
    if (pop)  rptr_d = rptr_q + ADDR_WIDTH'(1);
    if (wr_acc) begin
      if (push) begin
        acc_d   = '0;
        wlane_d = '0;
      end else begin
        acc_d   = wword;
        wlane_d = wlane_q + LW'(1);
      end
    end
    if (rd_acc) rlane_d = pop ? '0 : rlane_q + LW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      wlane_q <= '0;
      rlane_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      wlane_q <= wlane_d;
      rlane_q <= rlane_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.wr_last, wword};
  end

  assign bus.rd_dat     = empty ? '0 : OW'(head[W-1:0] >> rsh);
  assign bus.rd_last    = ~empty & head[W] & (rlane_q == LW'(RD_R - 1));
  assign bus.rd_empty   = empty;
  assign bus.wr_full    = full;
  assign bus.rd_dat_cnt = cnt_q;
  assign bus.err_ovf    = ovf_q;
  assign bus.err_udf    = udf_q;
endmodule
